// File: rtl/param_loader_pkg.sv
// Shared types for the parameter loader: storage geometry, address/count/word types and FSM states.
package param_loader_pkg;

    localparam int CIM_PARAMS_STORAGE_SIZE_NUM_ELEM = 31648;
    localparam int N_STO_PARAMS                     = 9;
    localparam int PARAM_ADDR_W  = $clog2(CIM_PARAMS_STORAGE_SIZE_NUM_ELEM);
    localparam int PARAM_COUNT_W = $clog2(CIM_PARAMS_STORAGE_SIZE_NUM_ELEM + 1);

    typedef logic [PARAM_ADDR_W-1:0]  ParamAddr_t;
    typedef logic [N_STO_PARAMS-1:0]  Param_t;
    typedef logic [PARAM_COUNT_W-1:0] ParamCount_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        STREAM,
        DONE
    } LoaderState_t;

    // 17 bits so base+num can exceed the 15-bit address space without wrapping.
    function automatic logic range_exceeded(input ParamAddr_t base, input ParamCount_t num,
                                            input int depth);
        logic [16:0] sum;
        logic [16:0] lim;
        sum = {2'b00, base} + {2'b00, num};
        lim = depth[16:0];
        return sum > lim;
    endfunction

endpackage

// File: rtl/param_loader.sv
// Streams parameter words from the load interface into the parameter storage write port,
// one word per cycle through a one-entry buffer that holds while storage withholds the grant.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | range / zero-length check of the latched request
// STREAM | accepting words and writing them to consecutive addresses
// DONE   | one-cycle completion pulse (with err_range if the check failed)
module param_loader
    import param_loader_pkg::*;
#(
    parameter int MEM_DEPTH = CIM_PARAMS_STORAGE_SIZE_NUM_ELEM,
    parameter int DATA_W    = N_STO_PARAMS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  ParamAddr_t        base_addr,
    input  ParamCount_t       num_words,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_wr_en,
    output ParamAddr_t        mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_gnt,
    output logic              busy,
    output logic              done,
    output logic              err_range
);

    LoaderState_t      state;
    ParamCount_t       num_q;
    ParamAddr_t        wr_addr;
    ParamCount_t       accepted_cnt;
    ParamCount_t       written_cnt;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;

    logic wr_fire;
    logic rd_fire;
    logic last_write;

    assign wr_fire    = buf_valid && mem_wr_gnt;
    assign s_ready    = (state == STREAM) && (accepted_cnt < num_q) && (!buf_valid || mem_wr_gnt);
    assign rd_fire    = s_valid && s_ready;
    assign last_write = wr_fire && (written_cnt == num_q - 1'b1);

    assign mem_wr_en   = buf_valid;
    assign mem_wr_addr = wr_addr;
    assign mem_wr_data = buf_data;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            num_q        <= '0;
            wr_addr      <= '0;
            accepted_cnt <= '0;
            written_cnt  <= '0;
            buf_valid    <= 1'b0;
            buf_data     <= '0;
            done         <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            done      <= 1'b0;
            err_range <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        num_q        <= num_words;
                        wr_addr      <= base_addr;
                        accepted_cnt <= '0;
                        written_cnt  <= '0;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (range_exceeded(wr_addr, num_q, MEM_DEPTH)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        err_range <= 1'b1;
                    end else if (num_q == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (abort) begin
                        state     <= IDLE;
                        buf_valid <= 1'b0;
                    end else begin
                        // Accept and consume in the same cycle reloads the buffer with no bubble.
                        if (rd_fire) begin
                            buf_valid    <= 1'b1;
                            buf_data     <= s_data;
                            accepted_cnt <= accepted_cnt + 1'b1;
                        end else if (wr_fire) begin
                            buf_valid <= 1'b0;
                        end
                        if (wr_fire) begin
                            wr_addr     <= wr_addr + 1'b1;
                            written_cnt <= written_cnt + 1'b1;
                        end
                        if (last_write) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    buf_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
